imul_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one fixed-latency iterative integer multiplier among `p_nreqs` requesters.
- Accepts 64-bit operand messages on per-requester val/rdy streams, grants exactly one at a time, forwards the message to the multiplier, and routes the 32-bit product back to the granting requester.
- Sits between client ports and a single multiplier instance, so the area-heavy multiplier is not replicated.

---
 rtl/imul_sched_pkg.sv | 14 +
 rtl/imul_rr_picker.sv | 31 +++
 rtl/imul_rr_scheduler.sv | 103 ++++++++++
 tb/tb_imul_rr_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imul_sched_pkg.sv
// rtl/imul_sched_pkg.sv - shared types and widths for the multiplier scheduler
package imul_sched_pkg;

    // FSM state: IDLE arbitrates requests, BUSY waits for the single in-flight result
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    // Operand message {a, b} and product widths
    localparam int OPND_W = 64;
    localparam int RES_W  = 32;

endpackage

// File: rtl/imul_rr_picker.sv
// rtl/imul_rr_picker.sv - combinational circular priority encoder
//   req   : request vector
//   prio  : id that has highest priority this cycle
//   grant : first requesting id found searching upward from prio (wrapping)
//   any   : at least one request present
module imul_rr_picker #(
    parameter int NREQS = 4,
    parameter int ID_W  = $clog2(NREQS)
) (
    input  logic [NREQS-1:0] req,
    input  logic [ID_W-1:0]  prio,
    output logic [ID_W-1:0]  grant,
    output logic             any
);

    // Walk from the farthest position back to prio so the nearest requester
    // (in circular order) is the last assignment and therefore wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = NREQS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(prio) + k) % NREQS;
            if (req[idx]) begin
                grant = ID_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imul_rr_scheduler.sv
// rtl/imul_rr_scheduler.sv - round-robin sharing of one iterative multiplier
//   clk, reset                  : clock, synchronous active-high reset
//   req_val/req_rdy/req_msg     : per-requester operand streams, {a, b} per 64-bit slot
//   resp_val/resp_rdy/resp_msg  : per-requester result streams, product broadcast
//   mul_istream_*               : operand stream toward the multiplier
//   mul_ostream_*               : result stream from the multiplier
module imul_rr_scheduler
    import imul_sched_pkg::*;
#(
    parameter int p_nreqs = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [p_nreqs-1:0]          req_val,
    output logic [p_nreqs-1:0]          req_rdy,
    input  logic [OPND_W*p_nreqs-1:0]   req_msg,
    output logic [p_nreqs-1:0]          resp_val,
    input  logic [p_nreqs-1:0]          resp_rdy,
    output logic [RES_W-1:0]            resp_msg,
    output logic                        mul_istream_val,
    input  logic                        mul_istream_rdy,
    output logic [OPND_W-1:0]           mul_istream_msg,
    input  logic                        mul_ostream_val,
    output logic                        mul_ostream_rdy,
    input  logic [RES_W-1:0]            mul_ostream_msg
);

    localparam int ID_W = $clog2(p_nreqs);

    sched_state_e    state, state_next;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] prio;
    logic [ID_W-1:0] grant;
    logic            any;
    logic            req_fire;
    logic            resp_fire;

    imul_rr_picker #(
        .NREQS (p_nreqs),
        .ID_W  (ID_W)
    ) u_picker (
        .req   (req_val),
        .prio  (prio),
        .grant (grant),
        .any   (any)
    );

    assign req_fire  = (state == IDLE) && mul_istream_val && mul_istream_rdy;
    assign resp_fire = (state == BUSY) && mul_ostream_val && mul_ostream_rdy;

    // Product only qualified by resp_val, so pass it straight through
    assign resp_msg = mul_ostream_msg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            prio  <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                owner <= grant;
            end
            if (resp_fire) begin
                prio <= (owner == ID_W'(p_nreqs - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    // Outputs are gated by reset so no handshake can be offered while the
    // state register is being cleared.
    always_comb begin
        state_next      = state;
        req_rdy         = '0;
        resp_val        = '0;
        mul_istream_val = 1'b0;
        mul_istream_msg = '0;
        mul_ostream_rdy = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        mul_istream_val = 1'b1;
                        mul_istream_msg = req_msg[int'(grant)*OPND_W +: OPND_W];
                        req_rdy[grant]  = mul_istream_rdy;
                        if (mul_istream_rdy) begin
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    resp_val[owner] = mul_ostream_val;
                    mul_ostream_rdy = resp_rdy[owner];
                    if (mul_ostream_val && resp_rdy[owner]) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imul_rr_scheduler.sv
// tb/tb_imul_rr_scheduler.sv - directed and randomized bench for imul_rr_scheduler
module tb_imul_rr_scheduler;

    localparam int N   = 4;
    localparam int LAT = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_val;
    logic [N-1:0]    req_rdy;
    logic [64*N-1:0] req_msg;
    logic [N-1:0]    resp_val;
    logic [N-1:0]    resp_rdy;
    logic [31:0]     resp_msg;
    logic            mul_istream_val;
    logic            mul_istream_rdy;
    logic [63:0]     mul_istream_msg;
    logic            mul_ostream_val;
    logic            mul_ostream_rdy;
    logic [31:0]     mul_ostream_msg;

    imul_rr_scheduler #(.p_nreqs(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_msg         (req_msg),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg        (resp_msg),
        .mul_istream_val (mul_istream_val),
        .mul_istream_rdy (mul_istream_rdy),
        .mul_istream_msg (mul_istream_msg),
        .mul_ostream_val (mul_ostream_val),
        .mul_ostream_rdy (mul_ostream_rdy),
        .mul_ostream_msg (mul_ostream_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fixed-latency multiplier sharing the scheduler reset
    logic        m_busy, m_done, m_stall;
    int          m_cnt;
    logic [31:0] m_res;

    assign mul_istream_rdy = !m_busy && !m_done && !m_stall;
    assign mul_ostream_val = m_done;
    assign mul_ostream_msg = m_res;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
        end else if (mul_istream_val && mul_istream_rdy) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_res  <= mul_istream_msg[63:32] * mul_istream_msg[31:0];
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (m_done && mul_ostream_rdy) begin
            m_done <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];

    logic [N-1:0] last_acc, last_resp_hs, last_resp_val, last_req_rdy;
    logic [31:0]  last_resp_msg;
    logic         last_ostream_rdy;
    int           rv_cnt [N];
    int           acc_q[$], ri_q[$];
    logic [31:0]  rm_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i] = a;
        op_b[i] = b;
        req_msg[64*i +: 64] = {a, b};
    endtask

    // Called just after a falling edge with inputs set: sample, cross one
    // rising edge, then withdraw any request that was accepted.
    task automatic tick();
        #1;
        last_acc         = req_val & req_rdy;
        last_resp_hs     = resp_val & resp_rdy;
        last_resp_val    = resp_val;
        last_resp_msg    = resp_msg;
        last_req_rdy     = req_rdy;
        last_ostream_rdy = mul_ostream_rdy;
        for (int i = 0; i < N; i++) rv_cnt[i] += int'(resp_val[i]);
        @(negedge clk);
        req_val = req_val & ~last_acc;
    endtask

    task automatic run(input string tag, input int n);
        int got = 0;
        int c = 0;
        acc_q.delete();
        ri_q.delete();
        rm_q.delete();
        while (got < n && c < 300) begin
            tick();
            c++;
            for (int i = 0; i < N; i++) if (last_acc[i]) acc_q.push_back(i);
            for (int i = 0; i < N; i++) if (last_resp_hs[i]) begin
                ri_q.push_back(i);
                rm_q.push_back(last_resp_msg);
                got++;
            end
        end
        chk({tag, "_responses"}, 64'(got), 64'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int c;
        int done;
        int exp_owner;
        logic [31:0] exp_prod;
        logic [N-1:0] pend;

        reset    = 1'b1;
        req_val  = '1;
        req_msg  = '0;
        resp_rdy = '1;
        m_stall  = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_op(i, 32'd0, 32'd0);
            rv_cnt[i] = 0;
        end

        // Outputs silent during reset even with every request valid
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_rdy", 64'(req_rdy), 64'h0);
        chk("reset_resp_val", 64'(resp_val), 64'h0);
        chk("reset_istream_val", 64'(mul_istream_val), 64'h0);
        chk("reset_ostream_rdy", 64'(mul_ostream_rdy), 64'h0);
        @(negedge clk);
        req_val = '0;
        reset   = 1'b0;

        // Single requester: 3 * 5, accepted immediately
        set_op(0, 32'd3, 32'd5);
        req_val = 4'b0001;
        for (int i = 0; i < N; i++) rv_cnt[i] = 0;
        run("single", 1);
        for (int k = 0; k < 4; k++) tick();
        chk("single_first_accept", 64'(acc_q.size() > 0 ? acc_q[0] : -1), 64'(0));
        chk("single_resp_idx", 64'(ri_q.size() > 0 ? ri_q[0] : -1), 64'(0));
        chk("single_product", 64'(rm_q.size() > 0 ? rm_q[0] : 32'hx), 64'd15);
        chk("single_pulses0", 64'(rv_cnt[0]), 64'd1);
        chk("single_pulses_other", 64'(rv_cnt[1] + rv_cnt[2] + rv_cnt[3]), 64'd0);

        // All four valid from prio 0: grants 0,1,2,3 with products 1..4
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd1);
        req_val = 4'b1111;
        run("all4", 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("all4_grant%0d", k), 64'(acc_q.size() > k ? acc_q[k] : -1), 64'(k));
            chk($sformatf("all4_ridx%0d", k), 64'(ri_q.size() > k ? ri_q[k] : -1), 64'(k));
            chk($sformatf("all4_prod%0d", k), 64'(rm_q.size() > k ? rm_q[k] : 32'hx), 64'(k + 1));
        end

        // Requester 2 alone, then 1 and 3 together: prio=3 favours 3
        set_op(2, 32'd6, 32'd7);
        req_val = 4'b0100;
        run("r2", 1);
        chk("r2_prod", 64'(rm_q.size() > 0 ? rm_q[0] : 32'hx), 64'd42);
        set_op(1, 32'd10, 32'd10);
        set_op(3, 32'd9, 32'd9);
        req_val = 4'b1010;
        run("r13", 2);
        chk("r13_first", 64'(acc_q.size() > 0 ? acc_q[0] : -1), 64'd3);
        chk("r13_second", 64'(acc_q.size() > 1 ? acc_q[1] : -1), 64'd1);
        chk("r13_prod_first", 64'(rm_q.size() > 0 ? rm_q[0] : 32'hx), 64'd81);
        chk("r13_prod_second", 64'(rm_q.size() > 1 ? rm_q[1] : 32'hx), 64'd100);

        // Owner 0 stalls its result for 10 cycles while requester 1 waits
        set_op(0, 32'hFFFF_FFFF, 32'd2);
        set_op(1, 32'd2, 32'd3);
        resp_rdy = 4'b1110;
        req_val  = 4'b0001;
        c = 0;
        last_acc = '0;
        while (!last_acc[0] && c < 20) begin tick(); c++; end
        chk("hold_accept0", 64'(last_acc), 64'b0001);
        req_val = 4'b0010;
        c = 0;
        last_resp_val = '0;
        while (!last_resp_val[0] && c < 50) begin tick(); c++; end
        chk("hold_resp_seen", 64'(last_resp_val), 64'b0001);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_resp_val", 64'(last_resp_val), 64'b0001);
            chk("hold_req_rdy", 64'(last_req_rdy), 64'h0);
            chk("hold_resp_msg", 64'(last_resp_msg), 64'hFFFF_FFFE);
            chk("hold_ostream_rdy", 64'(last_ostream_rdy), 64'h0);
        end
        resp_rdy = 4'b1111;
        tick();
        chk("release_resp_hs", 64'(last_resp_hs), 64'b0001);
        chk("release_no_same_cycle_accept", 64'(last_acc), 64'h0);
        run("after_hold", 1);
        chk("after_hold_grant", 64'(acc_q.size() > 0 ? acc_q[0] : -1), 64'd1);
        chk("after_hold_prod", 64'(rm_q.size() > 0 ? rm_q[0] : 32'hx), 64'd6);

        // Reset while BUSY (prio would otherwise be 2)
        set_op(2, 32'd5, 32'd5);
        req_val = 4'b0100;
        c = 0;
        last_acc = '0;
        while (!last_acc[2] && c < 20) begin tick(); c++; end
        chk("rst_busy_accept", 64'(last_acc), 64'b0100);
        tick();
        set_op(1, 32'd7, 32'd8);
        set_op(3, 32'd4, 32'd4);
        req_val = 4'b1010;
        reset   = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy_req_rdy", 64'(req_rdy), 64'h0);
        chk("rst_busy_resp_val", 64'(resp_val), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        run("post_reset", 2);
        chk("post_reset_first", 64'(acc_q.size() > 0 ? acc_q[0] : -1), 64'd1);
        chk("post_reset_ridx", 64'(ri_q.size() > 0 ? ri_q[0] : -1), 64'd1);
        chk("post_reset_prod", 64'(rm_q.size() > 0 ? rm_q[0] : 32'hx), 64'd56);
        chk("post_reset_prod2", 64'(rm_q.size() > 1 ? rm_q[1] : 32'hx), 64'd16);

        // Random stalls on every stream, 500 transactions
        pend      = '0;
        done      = 0;
        exp_owner = -1;
        exp_prod  = '0;
        c         = 0;
        while (done < 500 && c < 20000) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    set_op(i, $urandom, $urandom);
                    pend[i] = 1'b1;
                end
                req_val[i] = pend[i] && ($urandom_range(0, 9) < 7);
            end
            resp_rdy = N'($urandom);
            m_stall  = ($urandom_range(0, 2) == 0);
            tick();
            c++;
            if (|last_acc) begin
                chk("rnd_acc_onehot", 64'($onehot(last_acc)), 64'd1);
                chk("rnd_acc_while_busy", 64'(exp_owner), 64'hFFFF_FFFF_FFFF_FFFF);
                for (int i = 0; i < N; i++) if (last_acc[i]) begin
                    exp_owner = i;
                    exp_prod  = op_a[i] * op_b[i];
                    pend[i]   = 1'b0;
                end
            end
            if (|last_resp_hs) begin
                chk("rnd_resp_dest", 64'(last_resp_hs), 64'(exp_owner >= 0 ? (4'b0001 << exp_owner) : 4'b0000));
                chk("rnd_resp_prod", 64'(last_resp_msg), 64'(exp_prod));
                exp_owner = -1;
                done++;
            end
        end
        chk("rnd_completed", 64'(done), 64'd500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
